// File: rtl/ifu_fetch_buf.sv
// Instruction fetch unit: owns the PC, issues one memory request at a time and
// queues returned instructions with their PCs for decode; redirects flush the queue.
module ifu_fetch_buf #(
    parameter int unsigned      XLEN     = 64,
    parameter int unsigned      INST_W   = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h8000_0000,
    parameter int unsigned      PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         jb_i,
    input  logic [XLEN-1:0]              dnpc_i,
    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    output logic [XLEN-1:0]              mem_req_addr_o,
    input  logic                         mem_rsp_valid_i,
    input  logic [INST_W-1:0]            mem_rsp_inst_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [INST_W-1:0]            out_inst_o,
    output logic [XLEN-1:0]              out_pc_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_req_pc;
    logic [INST_W-1:0]   r_fifo_inst [DEPTH];
    logic [XLEN-1:0]     r_fifo_pc   [DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic                w_hs;
    logic                w_push;
    logic                w_pop;
    logic [CW-1:0]       w_cnt_nxt;

    assign w_hs      = (r_state == S_REQ) && mem_req_ready_i;
    // A redirect cancels both queue operations of the same cycle.
    assign w_push    = (r_state == S_WAIT) && mem_rsp_valid_i && !jb_i;
    assign w_pop     = (r_count != '0) && out_ready_i && !jb_i;
    assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        if (jb_i) begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_REQ;
                S_REQ:   w_state_nxt = mem_req_ready_i ? S_DROP : S_REQ;
                S_WAIT:  w_state_nxt = mem_rsp_valid_i ? S_REQ : S_DROP;
                S_DROP:  w_state_nxt = mem_rsp_valid_i ? S_REQ : S_DROP;
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < CW'(DEPTH))
                        w_state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (mem_req_ready_i)
                        w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rsp_valid_i)
                        w_state_nxt = (w_cnt_nxt < CW'(DEPTH)) ? S_REQ : S_IDLE;
                end
                S_DROP: begin
                    if (mem_rsp_valid_i)
                        w_state_nxt = S_REQ;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // A request accepted together with a redirect is stale, so the redirect target wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            if (jb_i)
                r_pc <= dnpc_i;
            else if (w_hs)
                r_pc <= r_pc + XLEN'(PC_STEP);
            if (w_hs)
                r_req_pc <= r_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo_inst[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (jb_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_inst[r_wr_ptr] <= mem_rsp_inst_i;
                r_fifo_pc[r_wr_ptr]   <= r_req_pc;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_cnt_nxt;
        end
    end

    assign mem_req_valid_o = (r_state == S_REQ);
    assign mem_req_addr_o  = r_pc;
    assign out_valid_o     = (r_count != '0);
    assign out_inst_o      = r_fifo_inst[r_rd_ptr];
    assign out_pc_o        = r_fifo_pc[r_rd_ptr];
    assign count_o         = r_count;

    // Requests are only issued with a free slot, so a push can never find the queue full.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        w_push |-> (r_count < CW'(DEPTH)));

endmodule

// File: doc/ifu_fetch_buf.md
Name: ifu_fetch_buf

Overview:
Parametrised next-generation instruction fetch unit with a decoupled fetch queue.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO, and presents them to decode over a valid/ready handshake.
- Handles jump/branch redirects: flushes the queue and discards in-flight stale responses. Sits between the PC/memory side and IDU.

Parameters:
XLEN, 64, PC/address width
INST_W, 32, instruction width
DEPTH, 4, fetch-queue entries; power of two, >= 2
RESET_PC, 64'h8000_0000, PC value after reset
PC_STEP, 4, PC increment per accepted request

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
jb_i  input  1  redirect request (jump/branch taken)
dnpc_i  input  XLEN  redirect target, sampled when jb_i=1
mem_req_valid_o  output  1  fetch request valid
mem_req_ready_i  input  1  memory accepts request
mem_req_addr_o  output  XLEN  fetch address (= pc register)
mem_rsp_valid_i  input  1  instruction response valid (always accepted)
mem_rsp_inst_i  input  INST_W  returned instruction
out_valid_o  output  1  queue head valid
out_ready_i  input  1  decode accepts head
out_inst_o  output  INST_W  head instruction
out_pc_o  output  XLEN  head PC
count_o  output  $clog2(DEPTH+1)  queue occupancy

Behaviour:
- Reset is async on rst posedge:
  - pc=RESET_PC, state=IDLE, FIFO pointers and count=0.
  - All outputs 0, except mem_req_addr_o=RESET_PC.
- FSM states:
  - IDLE: mem_req_valid_o=0. Goes to REQ when count<DEPTH; otherwise stays (queue full).
  - REQ: mem_req_valid_o=1. On mem_req_ready_i, pc<=pc+PC_STEP and state goes to WAIT. Address tracks pc and changes only on redirect.
  - WAIT: awaits mem_rsp_valid_i. On a response, push {pc_of_req, inst}. Go to REQ if count after this cycle's push/pop is <DEPTH, else IDLE.
  - DROP: awaits a response to discard. On mem_rsp_valid_i, discard it and go to REQ.
- Slot guarantee: a request is issued only from REQ, entered with count<DEPTH. Count rises only via the unit's own response, so every push has a free slot. Overflow is impossible; push-when-full is a design error (assertion).
- Request PC for the push is held in a req_pc register captured at request acceptance.
- FIFO: push on accepted response, pop on out_valid_o & out_ready_i. Simultaneous push/pop leaves count unchanged. Pointers wrap modulo DEPTH.
- out_valid_o = (count!=0). Head data is registered from the FIFO. Response in cycle N is visible at the output in cycle N+1.
- Redirect (jb_i=1) has priority over everything in the same cycle:
  - pc<=dnpc_i; FIFO flushed (count=0, pointers reset). Any same-cycle pop or push is cancelled.
  - IDLE -> REQ.
  - REQ without handshake -> REQ; the address becomes dnpc_i next cycle.
  - REQ with handshake the same cycle -> DROP. The accepted request is stale, and pc=dnpc_i, not dnpc_i+PC_STEP.
  - WAIT without response -> DROP.
  - WAIT with response the same cycle -> response discarded, go to REQ.
  - DROP with response the same cycle -> discard, go to REQ. DROP without response -> stay DROP.
- Throughput: at most one instruction per 2 cycles (REQ+WAIT) with single-cycle memory. This is acceptable for this generation.
- Reset mid-transaction: state returns to IDLE. Any response arriving after reset deasserts while in IDLE/REQ is ignored.

Test Plan:
- Reset release, mem_req_ready_i=1, responses 1 cycle after acceptance with inst=0x00000013 -> requests at 0x80000000, 0x80000004, 0x80000008; out_pc_o follows the same sequence; count_o stays <=1 with out_ready_i=1.
- out_ready_i=0, DEPTH=4 -> exactly 4 entries filled, count_o=4, state IDLE, mem_req_valid_o=0. Raise out_ready_i -> pops in order; the next request is issued at 0x80000010.
- jb_i=1, dnpc_i=0x80000100 in WAIT, with the stale response arriving 2 cycles later -> response discarded, count_o=0, next request address 0x80000100, queued PC 0x80000100.
- jb_i in the same cycle as request handshake at 0x80000008 (dnpc_i=0x80000200) -> DROP; the next response is discarded; the next request is at 0x80000200, not 0x80000204.
- Queue holds 3 entries; jb_i asserted with simultaneous out handshake and response -> count_o=0 next cycle, out_valid_o=0, nothing pushed.
- Assert rst asynchronously mid-WAIT -> outputs clear immediately without a clock edge; after release the first request is at RESET_PC.
